// File: rtl/pipe_ctrl_gen.sv
// Pipeline stall/flush/redirect controller for the in-order core, with held redirects and a stall watchdog.
// Optional performance counters are compiled in when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl_gen #(
    parameter int NUM_STAGES     = 6,
    parameter int ADDR_WIDTH     = 32,
    parameter int REDIRECT_STAGE = 3,
    parameter int WDOG_MAX       = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_STAGES-1:0] stallreq_i,
    input  logic                  jump_en_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                  trap_en_i,
    input  logic [ADDR_WIDTH-1:0] trap_addr_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  redirect_o,
    output logic [ADDR_WIDTH-1:0] new_pc_o,
    output logic                  pending_o,
    output logic                  watchdog_o,
    output logic [31:0]           stall_cycles_o,
    output logic [31:0]           redirect_cnt_o
);

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_TRAP,
        SEL_JUMP,
        SEL_HOLD,
        SEL_PEND
    } sel_t;

    function automatic logic [NUM_STAGES-1:0] range_mask(input int lo, input int hi);
        logic [NUM_STAGES-1:0] m;
        m = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            m[j] = (j >= lo) && (j <= hi);
        end
        return m;
    endfunction

    localparam logic [NUM_STAGES-1:0] TRAP_FLUSH  = range_mask(1, NUM_STAGES - 2);
    localparam logic [NUM_STAGES-1:0] REDIR_FLUSH = range_mask(1, REDIRECT_STAGE - 1);
    localparam logic [NUM_STAGES-1:0] REDIR_LOW   = range_mask(0, REDIRECT_STAGE - 1);
    localparam logic [NUM_STAGES-1:0] BLK_MASK    = range_mask(REDIRECT_STAGE, NUM_STAGES - 1);
    localparam logic [15:0]           WDOG_LIM    = 16'(WDOG_MAX);

    logic [NUM_STAGES-1:0] base_stall;
    logic [NUM_STAGES-1:0] base_flush;
    logic [NUM_STAGES-1:0] stall_c;
    logic [NUM_STAGES-1:0] flush_c;
    logic                  redirect_c;
    logic [ADDR_WIDTH-1:0] new_pc_c;
    logic                  blk;
    sel_t                  sel;

    logic                  pending;
    logic [ADDR_WIDTH-1:0] pend_addr;
    logic [15:0]           wdog_cnt;
    logic                  wdog_flag;

    // Everything at or below the highest requester holds; the register just above it takes a bubble.
    always_comb begin
        int  top;
        logic any;
        top        = 0;
        any        = 1'b0;
        base_stall = '0;
        base_flush = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            if (stallreq_i[j]) begin
                top = j;
                any = 1'b1;
            end
        end
        for (int j = 0; j < NUM_STAGES; j++) begin
            base_stall[j] = any && (j <= top);
            base_flush[j] = any && (j == top + 1);
        end
    end

    assign blk = |(stallreq_i & BLK_MASK);

    always_comb begin
        sel = SEL_NONE;
        if (trap_en_i) begin
            sel = SEL_TRAP;
        end else if (jump_en_i && !blk) begin
            sel = SEL_JUMP;
        end else if (jump_en_i) begin
            sel = SEL_HOLD;
        end else if (pending && !blk) begin
            sel = SEL_PEND;
        end
    end

    // NOTE: every output gets a default first so no path through the case leaves a latch.
    always_comb begin
        stall_c    = base_stall;
        flush_c    = base_flush;
        redirect_c = 1'b0;
        new_pc_c   = '0;
        case (sel)
            SEL_TRAP: begin
                stall_c    = '0;
                flush_c    = TRAP_FLUSH;
                redirect_c = 1'b1;
                new_pc_c   = trap_addr_i;
            end
            SEL_JUMP, SEL_PEND: begin
                stall_c    = base_stall & ~REDIR_LOW;
                flush_c    = base_flush | REDIR_FLUSH;
                redirect_c = 1'b1;
                new_pc_c   = (sel == SEL_JUMP) ? jump_addr_i : pend_addr;
            end
            default: ;
        endcase
    end

    // While reset is held the outputs are forced quiet regardless of inputs.
    assign stall_o    = rst_i ? stall_c    : '0;
    assign flush_o    = rst_i ? flush_c    : '0;
    assign redirect_o = rst_i ? redirect_c : 1'b0;
    assign new_pc_o   = rst_i ? new_pc_c   : '0;
    assign pending_o  = rst_i ? pending    : 1'b0;
    assign watchdog_o = rst_i ? wdog_flag  : 1'b0;

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pending   <= 1'b0;
            pend_addr <= '0;
        end else begin
            case (sel)
                SEL_HOLD: begin
                    pending   <= 1'b1;
                    pend_addr <= jump_addr_i;
                end
                SEL_TRAP, SEL_JUMP, SEL_PEND: pending <= 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wdog_cnt  <= '0;
            wdog_flag <= 1'b0;
        end else begin
            if (stall_c == '0 || trap_en_i) begin
                wdog_cnt <= '0;
            end else if (wdog_cnt != WDOG_LIM) begin
                wdog_cnt <= wdog_cnt + 16'd1;
            end
            if (wdog_cnt == WDOG_LIM) begin
                wdog_flag <= 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] redirect_cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cycles <= '0;
            redirect_cnt <= '0;
        end else begin
            if (stall_c[0]) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (redirect_c) begin
                redirect_cnt <= redirect_cnt + 32'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cycles;
    assign redirect_cnt_o = redirect_cnt;
`else
    assign stall_cycles_o = '0;
    assign redirect_cnt_o = '0;
`endif

endmodule
